// File: rtl/generador_pasos_pkg.sv
// Shared state encoding and default 50 MHz step timing for the stepper
// command front end.
package generador_pasos_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } estado_e;

  localparam int unsigned START_PERIOD_DEF = 500000;
  localparam int unsigned MIN_PERIOD_DEF   = 100000;
  localparam int unsigned RAMP_STEP_DEF    = 20000;

endpackage

// File: rtl/generador_pasos_temporizador_paso.sv
// Step interval timer: counts up from zero and flags the last cycle of the
// current period, then wraps to zero by itself.
module temporizador_paso
  import generador_pasos_pkg::*;
#(
  parameter int unsigned PER_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [PER_W-1:0] period,
  output logic             expire
);

  logic [PER_W-1:0] cnt_q;

  assign expire = (cnt_q == period - PER_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PER_W'(1);
    end
  end

endmodule

// File: rtl/generador_pasos.sv
// Move-command front end: accepts (steps, dir) and emits step pulses with a
// symmetric trapezoidal period ramp between START_PERIOD and MIN_PERIOD.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | move in progress, timer running, pulses on expiry
module generador_pasos
  import generador_pasos_pkg::*;
#(
  parameter int unsigned STEPS_W      = 16,
  parameter int unsigned PER_W        = 20,
  parameter int unsigned START_PERIOD = START_PERIOD_DEF,
  parameter int unsigned MIN_PERIOD   = MIN_PERIOD_DEF,
  parameter int unsigned RAMP_STEP    = RAMP_STEP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               abort,
  output logic               step_pulse,
  output logic               step_dir,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps_left
);

  localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] RAMP_P  = PER_W'(RAMP_STEP);

  estado_e            state_q, state_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic [STEPS_W-1:0] steps_left_q, steps_left_d;
  logic [STEPS_W-1:0] ramp_q, ramp_d;
  logic [PER_W-1:0]   period_q, period_d;

  logic               expire;
  logic               timer_clear;
  logic               pulse;
  logic [STEPS_W-1:0] n;
  logic [PER_W:0]     up_sum;
  logic [PER_W:0]     down_floor;

  temporizador_paso #(.PER_W(PER_W)) u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .period (period_q),
    .expire (expire)
  );

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    steps_left_d = steps_left_q;
    ramp_d       = ramp_q;
    period_d     = period_q;
    pulse        = 1'b0;
    timer_clear  = (state_q != RUN);
    n            = (steps_left_q != '0) ? steps_left_q - STEPS_W'(1) : '0;
    up_sum       = {1'b0, period_q} + {1'b0, RAMP_P};
    down_floor   = {1'b0, MIN_P} + {1'b0, RAMP_P};

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = RUN;
            dir_d        = cmd_dir;
            steps_left_d = cmd_steps;
            period_d     = START_P;
            ramp_d       = '0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          timer_clear = 1'b1;
        end else if (expire) begin
          pulse        = 1'b1;
          steps_left_d = n;
          // Decelerate once the remaining steps fit in the ramp already climbed.
          if (n <= ramp_q) begin
            period_d = (up_sum > {1'b0, START_P}) ? START_P : up_sum[PER_W-1:0];
            ramp_d   = (ramp_q != '0) ? ramp_q - STEPS_W'(1) : '0;
          end else if (period_q > MIN_P) begin
            period_d = ({1'b0, period_q} > down_floor) ? period_q - RAMP_P : MIN_P;
            ramp_d   = ramp_q + STEPS_W'(1);
          end
          if (n == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      steps_left_q <= '0;
      ramp_q       <= '0;
      period_q     <= START_P;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      steps_left_q <= steps_left_d;
      ramp_q       <= ramp_d;
      period_q     <= period_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign step_pulse = pulse & ~rst;
  assign step_dir   = dir_q;
  assign done       = done_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_generador_pasos.sv
// Scoreboard bench for generador_pasos with a short ramp (10 -> 4, step 2).
module tb_generador_pasos;

  localparam int STEPS_W = 16;
  localparam int PER_W   = 20;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_dir = 1'b0;
  logic [STEPS_W-1:0] cmd_steps = '0;
  logic               abort = 1'b0;
  logic               cmd_ready;
  logic               step_pulse;
  logic               step_dir;
  logic               busy;
  logic               done;
  logic [STEPS_W-1:0] steps_left;

  generador_pasos #(
    .STEPS_W      (STEPS_W),
    .PER_W        (PER_W),
    .START_PERIOD (10),
    .MIN_PERIOD   (4),
    .RAMP_STEP    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .abort      (abort),
    .step_pulse (step_pulse),
    .step_dir   (step_dir),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int at;
    bit dir;
    int left;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit d, input int at, input bit dir, input int left);
    ev_t e;
    e.is_done = d;
    e.at      = at;
    e.dir     = dir;
    e.left    = left;
    sb.push_back(e);
  endtask

  // Full move: pulses at the given intervals after accept, then done.
  task automatic push_move(input int acc, input bit dir, input int steps, input int iv[$]);
    int t;
    t = acc;
    for (int i = 0; i < iv.size(); i++) begin
      t += iv[i];
      push_ev(1'b0, t, dir, steps - i);
    end
    push_ev(1'b1, t + 1, dir, 0);
  endtask

  task automatic check_ev(input bit d);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s got=1 want=0 (cycle %0d)", d ? "done" : "pulse", cyc);
    end else begin
      e = sb.pop_front();
      chk(d ? "done_kind" : "pulse_kind", int'(d), int'(e.is_done));
      chk(d ? "done_cycle" : "pulse_cycle", cyc, e.at);
      if (!d) begin
        chk("pulse_dir", int'(step_dir), int'(e.dir));
        chk("pulse_left", int'(steps_left), e.left);
      end
    end
  endtask

  always @(negedge clk) begin
    if (step_pulse) check_ev(1'b0);
    if (done) check_ev(1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pulse"}, int'(step_pulse), 0);
    chk({tag, "_dir"}, int'(step_dir), 0);
    chk({tag, "_left"}, int'(steps_left), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    int a;
    int iv[$];

    rst = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 3-step move, dir=1: triangular 10, 8, 10
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd3; cmd_dir = 1'b1;
    iv = '{10, 8, 10};
    push_move(a, 1'b1, 3, iv);
    tick();
    cmd_valid = 1'b0;
    chk("m3_busy", int'(busy), 1);
    chk("m3_ready", int'(cmd_ready), 0);
    wait_until(a + 29);
    chk("m3_ready_at_done", int'(cmd_ready), 1);
    tick();
    chk("m3_left_end", int'(steps_left), 0);
    chk("m3_busy_end", int'(busy), 0);

    // zero-step command
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd0; cmd_dir = 1'b0;
    push_ev(1'b1, a + 1, 1'b0, 0);
    tick();
    cmd_valid = 1'b0;
    chk("zero_busy", int'(busy), 0);
    tick();
    chk("zero_busy2", int'(busy), 0);

    // 10-step move, dir=0: full trapezoid
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_dir = 1'b0;
    iv = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
    push_move(a, 1'b0, 10, iv);
    tick();
    cmd_valid = 1'b0;
    wait_until(a + 30);
    chk("m10_busy_mid", int'(busy), 1);
    wait_until(a + 64);
    chk("m10_busy_last", int'(busy), 1);
    wait_until(a + 66);
    chk("m10_busy_after", int'(busy), 0);

    // abort one cycle after the 3rd pulse, then a 2-step move
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_dir = 1'b1;
    push_ev(1'b0, a + 10, 1'b1, 10);
    push_ev(1'b0, a + 18, 1'b1, 9);
    push_ev(1'b0, a + 24, 1'b1, 8);
    tick();
    cmd_valid = 1'b0;
    wait_until(a + 25);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_left", int'(steps_left), 7);
    chk("abort_done", int'(done), 0);
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd2; cmd_dir = 1'b0;
    iv = '{10, 8};
    push_move(a, 1'b0, 2, iv);
    tick();
    cmd_valid = 1'b0;
    chk("after_abort_busy", int'(busy), 1);
    wait_until(a + 20);

    // abort in the same cycle as timer expiry
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd3; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    wait_until(a + 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_exp_left", int'(steps_left), 3);
    chk("abort_exp_busy", int'(busy), 0);
    tick();
    chk("abort_exp_done", int'(done), 0);

    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_ready", int'(cmd_ready), 1);

    // cmd_valid held with new values during RUN
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd3; cmd_dir = 1'b1;
    iv = '{10, 8, 10};
    push_move(a, 1'b1, 3, iv);
    iv = '{10, 8};
    push_move(a + 29, 1'b0, 2, iv);
    tick();
    cmd_steps = 16'd2; cmd_dir = 1'b0;
    wait_until(a + 5);
    chk("held_ready", int'(cmd_ready), 0);
    chk("held_dir", int'(step_dir), 1);
    wait_until(a + 30);
    cmd_valid = 1'b0;
    chk("held_accepted_busy", int'(busy), 1);
    chk("held_accepted_dir", int'(step_dir), 0);
    wait_until(a + 50);

    // rst in the cycle of timer expiry
    a = cyc;
    cmd_valid = 1'b1; cmd_steps = 16'd3; cmd_dir = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_until(a + 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst_mid");

    repeat (15) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
